// File: rtl/branch_pkg.sv
// Shared constants for branch resolution: condition codes, 2-bit PHT counter
// encodings and the saturating counter step used by the pattern-history table.
package branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_GEZ = 3'b001;
  localparam logic [2:0] BR_GTZ = 3'b010;
  localparam logic [2:0] BR_LEZ = 3'b011;
  localparam logic [2:0] BR_LTZ = 3'b100;
  localparam logic [2:0] BR_NE  = 3'b101;
  localparam logic [2:0] BR_GT  = 3'b110;
  localparam logic [2:0] BR_LT  = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] PHT_RST = WNT;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != ST)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != SNT)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result/fetch-lookup bundle between the pipeline and branch_resolve_unit.
// master = pipeline side, slave = the resolve unit.
interface branch_resolve_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       control;
  logic [31:0]      branch_pc;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             mispredict;
  logic             flush;
  logic [31:0]      fetch_pc;
  logic             fetch_pred_taken;

  modport master (
    output in_valid, in_a, in_b, control, branch_pc, pred_taken, out_ready, fetch_pc,
    input  in_ready, out_valid, taken, mispredict, flush, fetch_pred_taken
  );

  modport slave (
    input  in_valid, in_a, in_b, control, branch_pc, pred_taken, out_ready, fetch_pc,
    output in_ready, out_valid, taken, mispredict, flush, fetch_pred_taken
  );

endinterface

// File: rtl/branch_pht.sv
// Pattern-history table of 2-bit saturating counters with one update port and
// one read port; a read of the index being updated sees the post-update value.
module branch_pht
  import branch_pkg::*;
#(
  parameter int PHT_DEPTH = 64,
  localparam int IDX_W = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken
);

  logic [1:0] ctr [PHT_DEPTH];
  logic [1:0] rd_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++)
        ctr[i] <= PHT_RST;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

  // Write-through bypass so fetch never predicts from a stale counter.
  always_comb begin
    rd_ctr = ctr[rd_idx];
    if (upd_en && upd_idx == rd_idx)
      rd_ctr = ctr_next(ctr[upd_idx], upd_taken);
  end

  assign rd_taken = rd_ctr[1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: condition compare, mispredict/flush, PHT.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 64,
  localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
`endif
  branch_resolve_unit_if.slave bus
);

  logic             valid_q;
  logic             taken_q;
  logic             mis_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             xfer;
  logic             cond;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic             a_zero;
  logic             a_neg;
  logic             unused_pc_bits;

  assign sa     = $signed(bus.in_a);
  assign sb     = $signed(bus.in_b);
  assign a_zero = (bus.in_a == '0);
  assign a_neg  = bus.in_a[WIDTH-1];

  always_comb begin
    cond = 1'b0;
    case (bus.control)
      BR_EQ:   cond = (bus.in_a == bus.in_b);
      BR_GEZ:  cond = !a_neg;
      BR_GTZ:  cond = !a_neg && !a_zero;
      BR_LEZ:  cond = a_neg || a_zero;
      BR_LTZ:  cond = a_neg;
      BR_NE:   cond = (bus.in_a != bus.in_b);
      BR_GT:   cond = (sa > sb);
      BR_LT:   cond = (sa < sb);
      default: cond = 1'b0;
    endcase
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      taken_q <= cond;
      mis_q   <= (cond != bus.pred_taken);
      idx_q   <= bus.branch_pc[IDX_W+1:2];
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.taken      = taken_q;
  assign bus.mispredict = mis_q;
  assign bus.flush      = xfer && mis_q;

  branch_pht #(.PHT_DEPTH(PHT_DEPTH)) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_en    (xfer),
    .upd_idx   (idx_q),
    .upd_taken (taken_q),
    .rd_idx    (bus.fetch_pc[IDX_W+1:2]),
    .rd_taken  (bus.fetch_pred_taken)
  );

  // PC bits outside the word-aligned index do not participate.
  assign unused_pc_bits = ^{bus.branch_pc[31:IDX_W+2], bus.branch_pc[1:0],
                            bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0]};

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (xfer) begin
      if (branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (mis_q && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule
